demux_lane_deser: RTL

- Downstream consumer of the 1:6 bit demultiplexer.
- Captures the serial bit stream routed to each of the six demux outputs and assembles per-lane words.
- Buffers one completed word per lane and presents completed words, one at a time, on a valid/ready output port using round-robin arbitration.
- Sits between the demux and the word-level channel logic.

---
 rtl/demux_lane_deser_pkg.sv | 15 +
 rtl/demux_lane_deser_if.sv | 12 +
 rtl/demux_lane_deser_rr_arbiter_6.sv | 28 ++
 rtl/demux_lane_deser.sv | 104 ++++++++++
 4 files changed

// File: rtl/demux_lane_deser_pkg.sv
// rtl/demux_lane_deser_pkg.sv - shared constants and types for the demux lane deserializer
package demux_lane_deser_pkg;
    localparam int LANES  = 6;
    localparam int SEL_W  = 3;
    localparam int WORD_W = 8;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef logic [SEL_W-1:0]  lane_idx_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    function automatic lane_idx_t next_lane(input lane_idx_t g);
        return (g == lane_idx_t'(LANES - 1)) ? '0 : g + 1'b1;
    endfunction
endpackage

// File: rtl/demux_lane_deser_if.sv
// rtl/demux_lane_deser_if.sv - valid/ready word output port of the lane deserializer
interface demux_lane_deser_if;
    import demux_lane_deser_pkg::*;

    logic      out_valid;
    logic      out_ready;
    lane_idx_t out_lane;
    word_t     out_data;

    modport master (output out_valid, output out_lane, output out_data, input out_ready);
    modport slave  (input out_valid, input out_lane, input out_data, output out_ready);
endinterface

// File: rtl/demux_lane_deser_rr_arbiter_6.sv
// rtl/demux_lane_deser_rr_arbiter_6.sv - combinational round-robin pick over six lane requests
module rr_arbiter_6
    import demux_lane_deser_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  lane_idx_t        ptr,
    output lane_idx_t        grant,
    output logic             any_grant
);
    logic [SEL_W:0] idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        // walk from the farthest offset back toward ptr so the nearest requester wins
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (idx >= (SEL_W + 1)'(LANES)) begin
                idx = idx - (SEL_W + 1)'(LANES);
            end
            if (req[idx[SEL_W-1:0]]) begin
                grant     = idx[SEL_W-1:0];
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_lane_deser.sv
// rtl/demux_lane_deser.sv - per-lane word assembly behind the 1:6 demux, one hold per lane,
// round-robin drain onto a single registered valid/ready output
module demux_lane_deser
    import demux_lane_deser_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  lane_idx_t         sel,
    input  logic [LANES-1:0]  y,
    input  logic              lane_sync,
    demux_lane_deser_if.master dout,
    output logic [LANES-1:0]  overflow,
    input  logic              clear_ovf,
    output logic              sel_err
);
    // the shift register keeps only the WORD_W-1 earlier bits; the live bit completes the word
    logic [WORD_W-2:0] sr   [LANES];
    cnt_t              cnt  [LANES];
    word_t             hold [LANES];
    logic [LANES-1:0]  hold_full;
    logic [LANES-1:0]  hit;
    logic [LANES-1:0]  done;
    logic [LANES-1:0]  xfer;
    logic [LANES-1:0]  ovf_set;
    lane_idx_t         ptr;
    lane_idx_t         grant;
    logic              any_grant;
    logic              load;

    rr_arbiter_6 u_arb (
        .req       (hold_full),
        .ptr       (ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    assign load = any_grant && (!dout.out_valid || dout.out_ready);

    always_comb begin
        hit     = '0;
        done    = '0;
        xfer    = '0;
        ovf_set = '0;
        for (int i = 0; i < LANES; i++) begin
            hit[i]     = bit_valid && !lane_sync && (sel == lane_idx_t'(i));
            done[i]    = hit[i] && (cnt[i] == cnt_t'(WORD_W - 1));
            xfer[i]    = load && (grant == lane_idx_t'(i));
            // a hold emptied by this cycle's transfer may take the new word
            ovf_set[i] = done[i] && hold_full[i] && !xfer[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                sr[i]   <= '0;
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
            hold_full      <= '0;
            ptr            <= '0;
            overflow       <= '0;
            sel_err        <= 1'b0;
            dout.out_valid <= 1'b0;
            dout.out_lane  <= '0;
            dout.out_data  <= '0;
        end else begin
            sel_err <= bit_valid && (sel >= lane_idx_t'(LANES));

            for (int i = 0; i < LANES; i++) begin
                if (lane_sync) begin
                    sr[i]  <= '0;
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    sr[i]  <= {sr[i][WORD_W-3:0], y[i]};
                    cnt[i] <= done[i] ? '0 : cnt[i] + 1'b1;
                end

                if (done[i] && !ovf_set[i]) begin
                    hold[i]      <= {sr[i], y[i]};
                    hold_full[i] <= 1'b1;
                end else if (xfer[i]) begin
                    hold_full[i] <= 1'b0;
                end

                if (ovf_set[i]) begin
                    overflow[i] <= 1'b1;
                end else if (clear_ovf) begin
                    overflow[i] <= 1'b0;
                end
            end

            if (load) begin
                dout.out_valid <= 1'b1;
                dout.out_lane  <= grant;
                dout.out_data  <= hold[grant];
                ptr            <= next_lane(grant);
            end else if (dout.out_ready) begin
                dout.out_valid <= 1'b0;
            end
        end
    end
endmodule
